// File: rtl/debounce_defs.sv
// Shared definitions for the push-button input stage: debouncer FSM state
// encodings and constants used by the downstream rising_edge_detector.
package debounce_defs;

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH   = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW    = 2'd3;

    // Level the rising_edge_detector's history flop holds out of reset,
    // matching the debouncer's reset output so no spurious edge appears.
    localparam logic EDGE_DET_RESET_LEVEL = 1'b0;
    // Width in clock cycles of one rising_edge_detector output pulse.
    localparam int   EDGE_DET_PULSE_CYCLES = 1;

    // True while a candidate level change is being qualified.
    function automatic logic is_wait_state(input logic [1:0] state);
        return (state == WAIT_HIGH) || (state == WAIT_LOW);
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for a single asynchronous level; reset value 0.
module synchronizer (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values simply shift the input one stage down the chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Both stages clear while the active-low synchronous reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Mechanical switch debouncer: a level change is accepted only after
// STABLE_CYCLES consecutive synchronized samples at the new level.
module button_debouncer
    import debounce_defs::*;
#(
    parameter int STABLE_CYCLES = 100000,
    parameter int CNT_WIDTH     = 17
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_input,
    output logic debounced,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 sync_in;
    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 debounced_q, debounced_d;
    logic                 busy_q, busy_d;

    synchronizer u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw_input),
        .q   (sync_in)
    );

    // FSM next state: any reversal during a WAIT state restarts from scratch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        debounced_d = debounced_q;
        case (state_q)
            STABLE_LOW: begin
                if (sync_in) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = STABLE_HIGH;
                    debounced_d = 1'b1;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!sync_in) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = STABLE_LOW;
                    debounced_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = STABLE_LOW;
                cnt_d       = '0;
                debounced_d = 1'b0;
            end
        endcase
        busy_d = is_wait_state(state_d);
    end

    // State, counter and registered outputs, cleared by the active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= STABLE_LOW;
            cnt_q       <= '0;
            debounced_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            debounced_q <= debounced_d;
            busy_q      <= busy_d;
        end
    end

    assign debounced = debounced_q;
    assign busy      = busy_q;

endmodule
